// File: rtl/sub_bytes_engine.sv
`default_nettype none
// ============================================================================
// Module   : sub_bytes_engine
// Function : AES SubBytes / InvSubBytes over a 128-bit state, LANES bytes/cycle
// Revision : 1.0 - initial release
// ============================================================================
module sub_bytes_engine #(
  parameter int LANES  = 4,
  parameter int INV_EN = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in,
  input  logic         mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out,
  output logic         busy
);

  localparam int c_GROUPS = 16 / LANES;
  localparam int c_CW     = (c_GROUPS > 1) ? $clog2(c_GROUPS) : 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(c_GROUPS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          r_st;
  logic [c_CW-1:0] r_cnt;
  logic [127:0]    r_state;
  logic            r_mode;
  logic [4:0]      w_base;
  logic [7:0]      w_sub [LANES];
  logic [127:0]    w_next;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] p;
    logic [7:0] e;
    r = 8'h01;
    p = a;
    e = 8'hfe;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = gf_mul(r, p);
      p = gf_mul(p, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
    logic [7:0] v;
    v = gf_inv(x);
    return v ^ rotl(v, 1) ^ rotl(v, 2) ^ rotl(v, 3) ^ rotl(v, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] y);
    return gf_inv(rotl(y, 1) ^ rotl(y, 3) ^ rotl(y, 6) ^ 8'h05);
  endfunction

  assign w_base = 5'(r_cnt) * 5'(LANES);
  assign out    = r_state;

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    logic [7:0] w_in;
    assign w_in = r_state[8*(15 - (int'(w_base) + j)) +: 8];
    if (INV_EN != 0) begin : g_inv
      assign w_sub[j] = r_mode ? sbox_inv(w_in) : sbox_fwd(w_in);
    end else begin : g_fwd
      assign w_sub[j] = sbox_fwd(w_in);
    end
  end

  always_comb begin
    w_next = r_state;
    for (int j = 0; j < LANES; j++) begin
      w_next[8*(15 - (int'(w_base) + j)) +: 8] = w_sub[j];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_st      <= ST_IDLE;
      r_cnt     <= '0;
      r_state   <= 128'h0;
      r_mode    <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (r_st)
        ST_IDLE: begin
          if (in_valid) begin
            r_state  <= in;
            r_mode   <= mode;
            r_cnt    <= '0;
            r_st     <= ST_RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        ST_RUN: begin
          r_state <= w_next;
          if (r_cnt == c_LAST) begin
            r_cnt     <= '0;
            r_st      <= ST_DONE;
            out_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          // Re-arming in_ready only here keeps accept one cycle behind the handshake.
          if (out_ready) begin
            r_st      <= ST_IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          r_st      <= ST_IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sub_bytes_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_sub_bytes_engine
// Function : scoreboard bench for sub_bytes_engine across several lane widths
// Revision : 1.0 - initial release
// ============================================================================
module tb_sub_bytes_engine;

  localparam int c_NDUT = 4;
  localparam logic [2047:0] c_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  typedef struct {
    int           dut;
    logic [127:0] data;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         in_valid  [c_NDUT];
  logic         in_ready  [c_NDUT];
  logic [127:0] din       [c_NDUT];
  logic         mode      [c_NDUT];
  logic         out_valid [c_NDUT];
  logic         out_ready [c_NDUT];
  logic [127:0] dout      [c_NDUT];
  logic         busy      [c_NDUT];

  exp_t         sbq[$];
  int           n_checks;
  int           n_fail;
  logic [127:0] tv_in;
  logic [127:0] tv_exp;

  // Instance 0: LANES=4, 1: LANES=16, 2: LANES=1, 3: LANES=8 with inverse omitted.
  for (genvar i = 0; i < c_NDUT; i++) begin : g_dut
    localparam int c_LN = (i == 0) ? 4 : (i == 1) ? 16 : (i == 2) ? 1 : 8;
    localparam int c_IE = (i == 3) ? 0 : 1;
    sub_bytes_engine #(.LANES(c_LN), .INV_EN(c_IE)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[i]),
      .in_ready  (in_ready[i]),
      .in        (din[i]),
      .mode      (mode[i]),
      .out_valid (out_valid[i]),
      .out_ready (out_ready[i]),
      .out       (dout[i]),
      .busy      (busy[i])
    );
  end

  function automatic int lanes_of(input int d);
    case (d)
      0:       return 4;
      1:       return 16;
      2:       return 1;
      default: return 8;
    endcase
  endfunction

  function automatic logic [7:0] sbox_ref(input int x);
    return c_SBOX[2047 - 8*x -: 8];
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Monitor: every output handshake pops one expected block.
  always @(negedge clk) begin
    for (int i = 0; i < c_NDUT; i++) begin
      if (!rst && out_valid[i] && out_ready[i]) begin
        if (sbq.size() == 0) begin
          check("sb_unexpected_output", 128'(i), 128'hffff);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check("sb_dut_id", 128'(i), 128'(e.dut));
          check("sb_data", dout[i], e.data);
        end
      end
    end
  end

  task automatic run_block(input int d, input logic [127:0] data, input logic m,
                           input logic [127:0] exp, input int hold);
    int cyc;
    check("in_ready_before_accept", 128'(in_ready[d]), 128'd1);
    if (hold > 0) out_ready[d] = 1'b0;
    din[d] = data;
    mode[d] = m;
    in_valid[d] = 1'b1;
    sbq.push_back('{d, exp});
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
    mode[d] = ~m;
    din[d] = ~data;
    check("busy_after_accept", 128'(busy[d]), 128'd1);
    check("in_ready_after_accept", 128'(in_ready[d]), 128'd0);
    cyc = 0;
    while (!out_valid[d] && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("latency", 128'(cyc), 128'(16 / lanes_of(d)));
    for (int h = 0; h < hold; h++) begin
      check("hold_out", dout[d], exp);
      check("hold_valid", 128'(out_valid[d]), 128'd1);
      in_valid[d] = h[0];
      mode[d] = h[1];
      din[d] = {4{32'(h) * 32'h9e3779b9}};
      @(posedge clk); #1;
    end
    if (hold > 0) begin
      in_valid[d] = 1'b1;
      out_ready[d] = 1'b1;
      @(posedge clk); #1;
      in_valid[d] = 1'b0;
    end else begin
      @(posedge clk); #1;
    end
    check("in_ready_after_handshake", 128'(in_ready[d]), 128'd1);
    check("busy_after_handshake", 128'(busy[d]), 128'd0);
    check("out_valid_after_handshake", 128'(out_valid[d]), 128'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst = 1'b1;
    for (int i = 0; i < c_NDUT; i++) begin
      in_valid[i] = 1'b0;
      din[i] = 128'h0;
      mode[i] = 1'b0;
      out_ready[i] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < c_NDUT; i++) begin
      check("reset_in_ready", 128'(in_ready[i]), 128'd1);
      check("reset_out_valid", 128'(out_valid[i]), 128'd0);
      check("reset_busy", 128'(busy[i]), 128'd0);
      check("reset_state", dout[i], 128'h0);
    end

    run_block(0, 128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b0,
              128'hd42711aee0bf98f1b8b45de51e415230, 0);
    run_block(1, 128'hd42711aee0bf98f1b8b45de51e415230, 1'b1,
              128'h193de3bea0f4e22b9ac68d2ae9f84808, 0);
    run_block(2, {16{8'h8f}}, 1'b0, {16{8'h73}}, 0);
    run_block(2, {16{8'h00}}, 1'b0, {16{8'h63}}, 0);
    run_block(3, 128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b1,
              128'hd42711aee0bf98f1b8b45de51e415230, 0);

    // Backpressure with ignored input pulses and a mode toggle in DONE.
    run_block(0, 128'h00112233445566778899aabbccddeeff, 1'b0,
              128'h638293c31bfc33f5c4eeacea4bc12816, 10);

    // Reset during the second RUN cycle aborts the block.
    din[0] = 128'h0123456789abcdef0123456789abcdef;
    mode[0] = 1'b0;
    in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_in_ready", 128'(in_ready[0]), 128'd1);
    check("abort_out_valid", 128'(out_valid[0]), 128'd0);
    check("abort_busy", 128'(busy[0]), 128'd0);
    check("abort_state_cleared", dout[0], 128'h0);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      check("abort_no_out_valid", 128'(out_valid[0]), 128'd0);
    end

    // Reset takes priority over a simultaneous input.
    din[0] = 128'hffeeddccbbaa99887766554433221100;
    in_valid[0] = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid[0] = 1'b0;
    check("rst_vs_in_valid_busy", 128'(busy[0]), 128'd0);
    check("rst_vs_in_valid_in_ready", 128'(in_ready[0]), 128'd1);

    run_block(0, 128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b0,
              128'hd42711aee0bf98f1b8b45de51e415230, 0);

    // Every byte value through the 16-lane engine: forward, then inverse of forward.
    for (int blk = 0; blk < 16; blk++) begin
      for (int b = 0; b < 16; b++) begin
        tv_in[127 - 8*b -: 8]  = 8'(blk * 16 + b);
        tv_exp[127 - 8*b -: 8] = sbox_ref(blk * 16 + b);
      end
      run_block(1, tv_in, 1'b0, tv_exp, 0);
      run_block(1, tv_exp, 1'b1, tv_in, 0);
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 128'(sbq.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sub_bytes_engine.md
SUB_BYTES_ENGINE -- requirements
Module: sub_bytes_engine

Interface
REQ-001 Parameter LANES, default 4, S-box lanes per cycle; legal values 1, 2, 4, 8, 16 only.
REQ-002 Parameter INV_EN, default 1; 1 = inverse S-box supported, 0 = inverse logic omitted and mode ignored.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  input state presented.
REQ-006 in_ready  output  1  engine can accept a state.
REQ-007 in  input  128  AES state; byte 0 = in[127:120], byte 15 = in[7:0].
REQ-008 mode  input  1  0 = forward S-box (SubBytes), 1 = inverse S-box (InvSubBytes); sampled with in.
REQ-009 out_valid  output  1  result available.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 out  output  128  substituted state, same byte order as in.
REQ-012 busy  output  1  high in RUN or DONE.

Function
REQ-013 FSM states IDLE, RUN, DONE; encoding free.
REQ-014 IDLE: in_ready=1; in_valid=1 captures in and mode into internal state register, clears byte counter, -> RUN.
REQ-015 RUN: each cycle substitutes bytes [k*LANES .. k*LANES+LANES-1] in place, k = counter value; counter increments by 1.
REQ-016 RUN -> DONE on the edge that writes the final group (k = 16/LANES-1); counter width = clog2(16/LANES), min 1 bit.
REQ-017 Latency: out_valid rises exactly 16/LANES cycles after the accepting edge (LANES=16 -> 1 cycle, LANES=1 -> 16 cycles).
REQ-018 DONE: out_valid=1; out and out_valid held stable until out_ready=1; handshake edge -> IDLE.
REQ-019 in_ready=0 in RUN and DONE; in_valid there is ignored, no capture, no state corruption.
REQ-020 No same-cycle output-handshake/input-accept: next input accepted at earliest one cycle after out handshake.
REQ-021 out_valid, in_ready, busy are registered-state decodes only; no combinational path from out_ready or in_valid to any output.
REQ-022 Each lane: forward S-box per FIPS-197 table; inverse lane = exact inverse table; lane select by latched mode, not live mode input.
REQ-023 mode change while RUN or DONE has no effect on current block.
REQ-024 Bytes outside current group unchanged during a RUN cycle.
REQ-025 out = internal state register directly; content in IDLE undefined for checking, guaranteed only while out_valid=1.
REQ-026 INV_EN=0: mode=1 processed as forward.

Reset
REQ-027 rst=1 at a rising edge: FSM -> IDLE, counter -> 0, out_valid=0, in_ready=1 (first cycle after release), busy=0.
REQ-028 State register cleared to 128'h0 on reset.
REQ-029 Reset mid-RUN or in DONE aborts the block; no out_valid pulse produced for it.
REQ-030 rst dominates in_valid in same cycle: no capture.

Verification
REQ-031 LANES=4, mode=0, in=193de3bea0f4e22b9ac68d2ae9f84808 -> out_valid after 4 cycles, out=d42711aee0bf98f1b8b45de51e415230.
REQ-032 LANES=16, mode=1, in=d42711aee0bf98f1b8b45de51e415230 -> out_valid after 1 cycle, out=193de3bea0f4e22b9ac68d2ae9f84808.
REQ-033 LANES=1, mode=0, in all bytes 8f -> out_valid after 16 cycles, every byte 73; in all bytes 00 -> every byte 63.
REQ-034 Backpressure: out_ready held 0 for 10 cycles in DONE -> out, out_valid stable; in_valid pulses ignored; then out_ready=1 -> IDLE, in_ready=1 next cycle.
REQ-035 Reset at RUN cycle 2 (LANES=4) -> next cycle in_ready=1, out_valid=0, busy=0; subsequent block processes correctly.
REQ-036 Exhaustive lane check: all 256 byte values, both modes, inverse(forward(x)) = x.
